lcd_reader: RTL and testbench

//  Memory-mapped read engine for the HD44780-class character LCD on the 8-bit bus.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_reader_if.sv | 31 +++
 rtl/lcd_delay_cnt.sv | 26 ++
 rtl/lcd_reader.sv | 166 ++++++++++++++++
 tb/tb_lcd_reader.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared types and 50 MHz timing defaults for the HD44780-class LCD read and write engines.
package lcd_pkg;

   typedef enum logic [2:0] {
      RD_IDLE,
      RD_SETUP,
      RD_ENHI,
      RD_HOLD,
      RD_RECOVER,
      RD_DONE
   } rd_state_t;

   localparam logic [31:0] LCD_OFS_STATUS  = 32'd0;
   localparam logic [31:0] LCD_OFS_DATA    = 32'd1;
   localparam logic [31:0] LCD_BASEADDRESS = 32'h5000_0000;

   localparam int LCD_T_AS       = 7;
   localparam int LCD_T_PW       = 25;
   localparam int LCD_T_H        = 2;
   localparam int LCD_T_CYC      = 50;
   localparam int LCD_POLL_LIMIT = 1000;

   function automatic int lcd_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// CPU-side read port and LCD pad signals of the LCD read engine, plus FSM debug taps.
interface lcd_reader_if;
   import lcd_pkg::*;

   // RDSTB is taken only while the reader is idle and BUSY is low; it is a
   // one-cycle request with no back-pressure, so strobes seen otherwise are
   // dropped. RDVALID is a one-cycle pulse marking the cycle DATA_O changes.
   logic [31:0] ADDR;
   logic        RDSTB;
   logic [31:0] DATA_O;
   logic        RDVALID;
   logic        BUSY;
   logic [7:0]  LCD_DATA_I;
   logic        LCD_RS;
   logic        LCD_RW;
   logic        LCD_EN;
   logic        LCD_OWN;
   rd_state_t   state;
   logic [15:0] phase_cnt;

   modport slave (
      input  ADDR, RDSTB, LCD_DATA_I,
      output DATA_O, RDVALID, BUSY, LCD_RS, LCD_RW, LCD_EN, LCD_OWN, state, phase_cnt
   );

   modport master (
      output ADDR, RDSTB, LCD_DATA_I,
      input  DATA_O, RDVALID, BUSY, LCD_RS, LCD_RW, LCD_EN, LCD_OWN, state, phase_cnt
   );

endinterface

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter with zero flag; times LCD bus phases and counts busy polls.
module lcd_delay_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/lcd_reader.sv
// LCD read engine: one RW=1 bus cycle per accepted strobe, returning status or DDRAM/CGRAM byte.
// Optional busy-flag polling before data reads when LCD_RD_BUSY_POLL_EN is defined.
module lcd_reader
   import lcd_pkg::*;
#(
   parameter logic [31:0] BASEADDRESS = LCD_BASEADDRESS,
   parameter int          T_AS        = LCD_T_AS,
   parameter int          T_PW        = LCD_T_PW,
   parameter int          T_H         = LCD_T_H,
   parameter int          T_CYC       = LCD_T_CYC,
   parameter int          POLL_LIMIT  = LCD_POLL_LIMIT
) (
   input logic         ACLK,
   input logic         RESET,
   lcd_reader_if.slave bus
);

   localparam int T_REC = (T_CYC > T_AS + T_PW + T_H) ? (T_CYC - T_AS - T_PW - T_H) : 0;
   localparam int T_MAX = lcd_max(lcd_max(T_AS, T_PW), lcd_max(T_H, T_REC));
   localparam int CW    = (T_MAX < 1) ? 1 : $clog2(T_MAX + 1);

   rd_state_t   state, state_n;
   logic        phase_rs, rs_n;
   logic        timeout, timeout_n;
   logic [7:0]  rd_byte;
   logic        accept, step, in_range;
   logic        cnt_zero;
   logic [CW-1:0] phase_count, cnt_val;

   // First phase at or after s whose duration is non-zero; RD_DONE means the bus cycle is over.
   function automatic rd_state_t first_phase(input rd_state_t s);
      rd_state_t r;
      r = RD_DONE;
      if ((s <= RD_RECOVER) && (T_REC > 0)) r = RD_RECOVER;
      if ((s <= RD_HOLD)    && (T_H   > 0)) r = RD_HOLD;
      if ((s <= RD_ENHI)    && (T_PW  > 0)) r = RD_ENHI;
      if ((s <= RD_SETUP)   && (T_AS  > 0)) r = RD_SETUP;
      return r;
   endfunction

   function automatic logic [CW-1:0] phase_len(input rd_state_t s);
      case (s)
         RD_SETUP:   return CW'(T_AS - 1);
         RD_ENHI:    return CW'(T_PW - 1);
         RD_HOLD:    return CW'(T_H - 1);
         RD_RECOVER: return CW'(T_REC - 1);
         default:    return '0;
      endcase
   endfunction

   assign in_range = (bus.ADDR == BASEADDRESS + LCD_OFS_STATUS) ||
                     (bus.ADDR == BASEADDRESS + LCD_OFS_DATA);
   assign accept   = (state == RD_IDLE) && !bus.BUSY && bus.RDSTB && in_range;

`ifdef LCD_RD_BUSY_POLL_EN
   localparam int PW = (POLL_LIMIT < 1) ? 1 : $clog2(POLL_LIMIT + 1);
   logic          req_data, req_n;
   logic          poll_dec, poll_zero;
   logic [PW-1:0] poll_count;
   logic [7:0]    byte_n;

   assign req_n  = accept ? bus.ADDR[0] : req_data;
   // When HOLD/RECOVER are skipped the status byte is still on the pad this cycle.
   assign byte_n = (state == RD_ENHI) ? bus.LCD_DATA_I : rd_byte;

   lcd_delay_cnt #(.W(PW)) u_poll_cnt (
      .clk      (ACLK),
      .rst      (RESET),
      .load     (accept),
      .dec      (poll_dec),
      .load_val (PW'(POLL_LIMIT)),
      .count    (poll_count),
      .zero     (poll_zero)
   );
`endif

   always_comb begin
      state_n   = state;
      rs_n      = phase_rs;
      timeout_n = timeout;
      step      = 1'b0;
`ifdef LCD_RD_BUSY_POLL_EN
      poll_dec  = 1'b0;
`endif
      case (state)
         RD_IDLE:    if (accept)   begin step = 1'b1; state_n = first_phase(RD_SETUP);   end
         RD_SETUP:   if (cnt_zero) begin step = 1'b1; state_n = first_phase(RD_ENHI);    end
         RD_ENHI:    if (cnt_zero) begin step = 1'b1; state_n = first_phase(RD_HOLD);    end
         RD_HOLD:    if (cnt_zero) begin step = 1'b1; state_n = first_phase(RD_RECOVER); end
         RD_RECOVER: if (cnt_zero) begin step = 1'b1; state_n = RD_DONE;                 end
         default:    state_n = RD_IDLE;
      endcase
      if (accept) begin
         timeout_n = 1'b0;
`ifdef LCD_RD_BUSY_POLL_EN
         rs_n = 1'b0;
`else
         rs_n = bus.ADDR[0];
`endif
      end
`ifdef LCD_RD_BUSY_POLL_EN
      // A finished status cycle on behalf of a data read decides: data cycle, another poll, or timeout.
      if (step && (state_n == RD_DONE) && !rs_n && req_n) begin
         if (!byte_n[7]) begin
            rs_n    = 1'b1;
            state_n = first_phase(RD_SETUP);
         end else if (poll_zero || (poll_count == PW'(1))) begin
            timeout_n = 1'b1;
         end else begin
            poll_dec = 1'b1;
            state_n  = first_phase(RD_SETUP);
         end
      end
`endif
      cnt_val = phase_len(state_n);
   end

   lcd_delay_cnt #(.W(CW)) u_phase_cnt (
      .clk      (ACLK),
      .rst      (RESET),
      .load     (step),
      .dec      (!step),
      .load_val (cnt_val),
      .count    (phase_count),
      .zero     (cnt_zero)
   );

   assign bus.state     = state;
   assign bus.phase_cnt = 16'(phase_count);

   // Pad and CPU outputs are registered decodes of the current state, so they trail it by one cycle.
   always_ff @(posedge ACLK) begin
      if (RESET) begin
         state       <= RD_IDLE;
         phase_rs    <= 1'b0;
         timeout     <= 1'b0;
         rd_byte     <= 8'd0;
         bus.DATA_O  <= 32'd0;
         bus.RDVALID <= 1'b0;
         bus.BUSY    <= 1'b0;
         bus.LCD_EN  <= 1'b0;
         bus.LCD_RW  <= 1'b0;
         bus.LCD_RS  <= 1'b0;
         bus.LCD_OWN <= 1'b0;
`ifdef LCD_RD_BUSY_POLL_EN
         req_data    <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         phase_rs <= rs_n;
         timeout  <= timeout_n;
`ifdef LCD_RD_BUSY_POLL_EN
         req_data <= req_n;
`endif
         if ((state == RD_ENHI) && cnt_zero) rd_byte <= bus.LCD_DATA_I;
         bus.LCD_EN  <= (state == RD_ENHI);
         bus.LCD_OWN <= (state == RD_SETUP) || (state == RD_ENHI) || (state == RD_HOLD);
         bus.LCD_RW  <= (state == RD_SETUP) || (state == RD_ENHI) || (state == RD_HOLD);
         bus.LCD_RS  <= ((state == RD_SETUP) || (state == RD_ENHI) || (state == RD_HOLD)) && phase_rs;
         bus.RDVALID <= (state == RD_DONE);
         bus.BUSY    <= (state != RD_IDLE);
         if (state == RD_DONE) bus.DATA_O <= {timeout, 23'd0, rd_byte};
      end
   end

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: timing, data return, ignored strobes, reset abort, busy polling.
module tb_lcd_reader;
   import lcd_pkg::*;

   localparam logic [31:0] BASE = 32'h5000_0000;
`ifdef LCD_RD_BUSY_POLL_EN
   localparam int POLL_ON = 1;
`else
   localparam int POLL_ON = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   lcd_reader_if bus();

   logic [7:0] pad_stat = 8'h00;
   logic [7:0] pad_busy = 8'hFF;
   logic [7:0] pad_data = 8'h00;
   int busy_polls = 0;
   int stat_rises = 0;
   int stat_base  = 0;
   int checks = 0;
   int errors = 0;

   int en_first, en_hi, en_pulses, st_pulses, dt_pulses, own_hi, busy_hi, valid_k, valid_cnt, rw_bad;

   always #10 clk = ~clk;

   lcd_reader #(.POLL_LIMIT(4)) dut (
      .ACLK  (clk),
      .RESET (rst),
      .bus   (bus)
   );

   // LCD pad model: status byte reports BF=1 for the first busy_polls status pulses of a read.
   always @(posedge bus.LCD_EN) if (!bus.LCD_RS) stat_rises = stat_rises + 1;
   assign bus.LCD_DATA_I = bus.LCD_RS ? pad_data :
                           (((stat_rises - stat_base) <= busy_polls) ? pad_busy : pad_stat);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Strobe one read, then observe `cycles` negedges; re_k injects an extra strobe at that sample.
   task automatic do_read(input logic [31:0] a, input int cycles, input int re_k);
      logic prev_en;
      prev_en = 1'b0;
      en_first = -1; en_hi = 0; en_pulses = 0; st_pulses = 0; dt_pulses = 0;
      own_hi = 0; busy_hi = 0; valid_k = -1; valid_cnt = 0; rw_bad = 0;
      stat_base = stat_rises;
      @(negedge clk);
      bus.ADDR  = a;
      bus.RDSTB = 1'b1;
      for (int k = 0; k <= cycles; k++) begin
         @(negedge clk);
         bus.RDSTB = (k == re_k);
         if (k == re_k) bus.ADDR = BASE;
         if (bus.LCD_EN) begin
            en_hi++;
            if (!prev_en) begin
               en_pulses++;
               if (en_first < 0) en_first = k;
               if (bus.LCD_RS) dt_pulses++; else st_pulses++;
            end
            if (!bus.LCD_RW) rw_bad++;
         end
         prev_en = bus.LCD_EN;
         if (bus.LCD_OWN) own_hi++;
         if (bus.BUSY) busy_hi++;
         if (bus.RDVALID) begin
            valid_cnt++;
            if (valid_k < 0) valid_k = k;
         end
      end
      bus.RDSTB = 1'b0;
   endtask

   initial begin
      int lost_valid;
      bus.ADDR  = 32'd0;
      bus.RDSTB = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data_o",  bus.DATA_O,  32'd0);
      check("rst_rdvalid", 32'(bus.RDVALID), 32'd0);
      check("rst_busy",    32'(bus.BUSY),    32'd0);
      check("rst_en",      32'(bus.LCD_EN),  32'd0);
      check("rst_rw",      32'(bus.LCD_RW),  32'd0);
      check("rst_rs",      32'(bus.LCD_RS),  32'd0);
      check("rst_own",     32'(bus.LCD_OWN), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Status read
      pad_stat = 8'h8A; busy_polls = 0;
      do_read(BASE, 60, -1);
      check("t1_en_first", 32'(en_first),  32'd8);
      check("t1_en_width", 32'(en_hi),     32'd25);
      check("t1_st_pulse", 32'(st_pulses), 32'd1);
      check("t1_dt_pulse", 32'(dt_pulses), 32'd0);
      check("t1_rw_bad",   32'(rw_bad),    32'd0);
      check("t1_own_hi",   32'(own_hi),    32'd34);
      check("t1_valid_k",  32'(valid_k),   32'd51);
      check("t1_valid_n",  32'(valid_cnt), 32'd1);
      check("t1_data_o",   bus.DATA_O,     32'h0000_008A);

      // Data read with a stray strobe while busy
      pad_stat = 8'h0A; pad_data = 8'h41;
      do_read(BASE + 32'd1, 120, 20);
      check("t2_st_pulse", 32'(st_pulses), 32'(POLL_ON));
      check("t2_dt_pulse", 32'(dt_pulses), 32'd1);
      check("t2_busy_hi",  32'(busy_hi),   32'(51 + 50 * POLL_ON));
      check("t2_valid_n",  32'(valid_cnt), 32'd1);
      check("t2_data_o",   bus.DATA_O,     32'h0000_0041);

      // Out-of-range strobe
      pad_data = 8'h77;
      do_read(BASE + 32'd2, 60, -1);
      check("t3_en_pulse", 32'(en_pulses), 32'd0);
      check("t3_valid_n",  32'(valid_cnt), 32'd0);
      check("t3_busy_hi",  32'(busy_hi),   32'd0);
      check("t3_data_o",   bus.DATA_O,     32'h0000_0041);

      // Reset during ENHI
      pad_data = 8'h99;
      @(negedge clk);
      bus.ADDR = BASE; bus.RDSTB = 1'b1;
      @(negedge clk);
      bus.RDSTB = 1'b0;
      repeat (15) @(negedge clk);
      check("t4_en_before", 32'(bus.LCD_EN), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t4_en",      32'(bus.LCD_EN),  32'd0);
      check("t4_rw",      32'(bus.LCD_RW),  32'd0);
      check("t4_own",     32'(bus.LCD_OWN), 32'd0);
      check("t4_busy",    32'(bus.BUSY),    32'd0);
      check("t4_data_o",  bus.DATA_O,       32'd0);
      rst = 1'b0;
      lost_valid = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (bus.RDVALID) lost_valid++;
      end
      check("t4_no_valid", 32'(lost_valid), 32'd0);
      pad_data = 8'h3C;
      do_read(BASE + 32'd1, 120, -1);
      check("t4_rd_valid_n", 32'(valid_cnt), 32'd1);
      check("t4_rd_data_o",  bus.DATA_O,     32'h0000_003C);

`ifdef LCD_RD_BUSY_POLL_EN
      // Busy for three polls, then ready
      pad_busy = 8'h83; pad_stat = 8'h03; pad_data = 8'h5A; busy_polls = 3;
      do_read(BASE + 32'd1, 300, -1);
      check("t5_st_pulse", 32'(st_pulses), 32'd4);
      check("t5_dt_pulse", 32'(dt_pulses), 32'd1);
      check("t5_valid_k",  32'(valid_k),   32'd251);
      check("t5_data_o",   bus.DATA_O,     32'h0000_005A);

      // Busy flag stuck: timeout after POLL_LIMIT polls
      pad_busy = 8'hFF; busy_polls = 100000;
      do_read(BASE + 32'd1, 260, -1);
      check("t6_st_pulse", 32'(st_pulses), 32'd4);
      check("t6_dt_pulse", 32'(dt_pulses), 32'd0);
      check("t6_valid_k",  32'(valid_k),   32'd201);
      check("t6_data_o",   bus.DATA_O,     32'h8000_00FF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
